// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART link: serial line and frame configuration toward the
// receiver, received word and one-cycle status strobes back to the system controller.
interface uart_rx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_ERR;
  logic                      STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: LSB-first frames with optional parity, one-cycle outcome strobes.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the bit centre.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave rx_if
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]             BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0]             BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]             BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ZERO  = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  logic rx_meta_r, rx_sync_r, rx_s;
  state_t state_r, state_nx;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_r, edge_cnt_nx, prescale_r, half_s;
  logic [BW-1:0] bit_cnt_r, bit_cnt_nx;
  logic [DATA_WIDTH-1:0] shift_r, shift_nx, p_data_r, p_data_nx;
  logic par_en_r, par_typ_r, cfg_load_s;
  logic par_bad_r, par_bad_nx, stp_bad_r, stp_bad_nx, glitch_r, glitch_nx;
  logic armed_r, armed_nx;
  logic data_valid_r, data_valid_nx, par_err_r, par_err_nx, stp_err_r, stp_err_nx;
  logic last_edge_s, sample_ev_s, bit_val_s;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_if.RX_IN;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign rx_s        = rx_sync_r;
  assign half_s      = {1'b0, prescale_r[PRESCALE_WIDTH-1:1]};
  assign last_edge_s = (edge_cnt_r == prescale_r - PS_ONE);

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic maj_a_r, maj_b_r;

  // Early and centre samples held for the vote taken one cycle after the centre.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      maj_a_r <= 1'b1;
      maj_b_r <= 1'b1;
    end else begin
      if (edge_cnt_r == half_s - PS_ONE) maj_a_r <= rx_s;
      if (edge_cnt_r == half_s)          maj_b_r <= rx_s;
    end
  end

  assign sample_ev_s = (edge_cnt_r == half_s + PS_ONE);
  assign bit_val_s   = maj3(maj_a_r, maj_b_r, rx_s);
`else
  assign sample_ev_s = (edge_cnt_r == half_s);
  assign bit_val_s   = rx_s;
`endif

  // Next-state, counter and outcome decisions; the edge counter wraps at each bit end.
  always_comb begin
    state_nx      = state_r;
    edge_cnt_nx   = last_edge_s ? PS_ZERO : edge_cnt_r + PS_ONE;
    bit_cnt_nx    = bit_cnt_r;
    shift_nx      = shift_r;
    par_bad_nx    = par_bad_r;
    stp_bad_nx    = stp_bad_r;
    glitch_nx     = glitch_r;
    armed_nx      = armed_r;
    cfg_load_s    = 1'b0;
    p_data_nx     = p_data_r;
    data_valid_nx = 1'b0;
    par_err_nx    = 1'b0;
    stp_err_nx    = 1'b0;
    case (state_r)
      IDLE: begin
        edge_cnt_nx = PS_ZERO;
        if (armed_r && !rx_s) begin
          // The detecting cycle is edge 0 of the start bit.
          state_nx    = START;
          edge_cnt_nx = PS_ONE;
          cfg_load_s  = 1'b1;
          bit_cnt_nx  = BIT_ZERO;
          par_bad_nx  = 1'b0;
          stp_bad_nx  = 1'b0;
          glitch_nx   = 1'b0;
        end else if (rx_s) begin
          armed_nx = 1'b1;
        end else begin
          armed_nx = armed_r;
        end
      end
      START: begin
        if (sample_ev_s) glitch_nx = bit_val_s;
        else             glitch_nx = glitch_r;
        if (last_edge_s) state_nx = glitch_r ? IDLE : DATA;
        else             state_nx = START;
      end
      DATA: begin
        if (sample_ev_s) shift_nx = {bit_val_s, shift_r[DATA_WIDTH-1:1]};
        else             shift_nx = shift_r;
        if (last_edge_s && (bit_cnt_r == BIT_LAST)) begin
          bit_cnt_nx = BIT_ZERO;
          state_nx   = par_en_r ? PARITY : STOP;
        end else if (last_edge_s) begin
          bit_cnt_nx = bit_cnt_r + BIT_ONE;
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
      end
      PARITY: begin
        if (sample_ev_s) par_bad_nx = (bit_val_s != (parity_of(shift_r) ^ par_typ_r));
        else             par_bad_nx = par_bad_r;
        if (last_edge_s) state_nx = STOP;
        else             state_nx = PARITY;
      end
      STOP: begin
        if (sample_ev_s) stp_bad_nx = !bit_val_s;
        else             stp_bad_nx = stp_bad_r;
        if (last_edge_s) begin
          state_nx = IDLE;
          armed_nx = !stp_bad_r;
          if (par_bad_r || stp_bad_r) begin
            par_err_nx = par_bad_r;
            stp_err_nx = stp_bad_r;
          end else begin
            data_valid_nx = 1'b1;
            p_data_nx     = shift_r;
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx    = IDLE;
        edge_cnt_nx = PS_ZERO;
      end
    endcase
  end

  // FSM state, counters, captured frame configuration and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= IDLE;
      edge_cnt_r   <= PS_ZERO;
      bit_cnt_r    <= BIT_ZERO;
      shift_r      <= {DATA_WIDTH{1'b0}};
      prescale_r   <= PS_ZERO;
      par_en_r     <= 1'b0;
      par_typ_r    <= 1'b0;
      par_bad_r    <= 1'b0;
      stp_bad_r    <= 1'b0;
      glitch_r     <= 1'b0;
      armed_r      <= 1'b1;
      p_data_r     <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nx;
      edge_cnt_r   <= edge_cnt_nx;
      bit_cnt_r    <= bit_cnt_nx;
      shift_r      <= shift_nx;
      par_bad_r    <= par_bad_nx;
      stp_bad_r    <= stp_bad_nx;
      glitch_r     <= glitch_nx;
      armed_r      <= armed_nx;
      p_data_r     <= p_data_nx;
      data_valid_r <= data_valid_nx;
      par_err_r    <= par_err_nx;
      stp_err_r    <= stp_err_nx;
      if (cfg_load_s) begin
        prescale_r <= rx_if.PRESCALE;
        par_en_r   <= rx_if.PAR_EN;
        par_typ_r  <= rx_if.PAR_TYP;
      end
    end
  end

  assign rx_if.P_DATA     = p_data_r;
  assign rx_if.DATA_VALID = data_valid_r;
  assign rx_if.PAR_ERR    = par_err_r;
  assign rx_if.STP_ERR    = stp_err_r;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();
  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (.CLK(CLK), .RST(RST), .rx_if(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; logic dv; logic pe; logic se; logic [DW-1:0] pd; } evt_t;
  evt_t evq[$];

  // Every strobe cycle is logged, so a widened strobe shows up as an extra event.
  always @(negedge CLK) begin
    if (RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR))
      evq.push_back('{cyc, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA});
  end

  typedef struct {
    int p; logic pe; logic pt; logic [DW-1:0] d; logic flip; logic stop;
    logic dv; logic perr; logic serr; logic [DW-1:0] pd;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.RX_IN = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int pick_prescale();
    int sel;
    sel = $urandom_range(0, 2);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
  endfunction

  task automatic send_frame(input int p, input logic pe, input logic pt, input logic [DW-1:0] d,
                            input logic flip, input logic stop, input logic scramble, output int fall);
    bus.PRESCALE = p[PW-1:0];
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    fall = cyc;
    hold(1'b0, p);
    if (scramble) begin
      bus.PRESCALE = pick_prescale();
      bus.PAR_EN   = 1'($urandom_range(0, 1));
      bus.PAR_TYP  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < DW; i++) hold(d[i], p);
    if (pe) hold(1'(($countones(d) + pt + flip) % 2), p);
    hold(stop, p);
  endtask

  task automatic expect_frame(input string name, input int fall, input int n, input logic dv,
                              input logic pe, input logic se, input logic [DW-1:0] pd);
    evt_t e;
    int due;
    due = fall + n + 2;
    while (cyc < due + 2) @(posedge CLK);
    @(negedge CLK);
    chk({name, " strobe count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({name, " latency"}, e.cyc - fall, n + 2);
      chk({name, " DATA_VALID"}, e.dv, dv);
      chk({name, " PAR_ERR"}, e.pe, pe);
      chk({name, " STP_ERR"}, e.se, se);
    end
    chk({name, " P_DATA"}, bus.P_DATA, pd);
    evq.delete();
  endtask

  initial begin
    int fall, f0, p, n, gap;
    logic pe, pt, flip, stop, scr, exp_pe, exp_se, exp_dv;
    logic [DW-1:0] d, last_pd, maj_exp;
    evt_t e0, e1, e2;

    tbl[0] = '{8,  1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA};
    tbl[1] = '{16, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h35};
    tbl[2] = '{16, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h35};
    tbl[3] = '{16, 1'b1, 1'b1, 8'hC7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC7};
    tbl[4] = '{32, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC7};
    tbl[5] = '{8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{32, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96};

    RST = 1'b0;
    bus.RX_IN = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset P_DATA", bus.P_DATA, 0);
    chk("reset DATA_VALID", bus.DATA_VALID, 0);
    chk("reset PAR_ERR", bus.PAR_ERR, 0);
    chk("reset STP_ERR", bus.STP_ERR, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    hold(1'b1, 4);

    for (int i = 0; i < 7; i++) begin
      hold(1'b1, 3);
      send_frame(tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].d, tbl[i].flip, tbl[i].stop, 1'b0, fall);
      expect_frame($sformatf("vec%0d", i), fall, (2 + DW + int'(tbl[i].pe)) * tbl[i].p,
                   tbl[i].dv, tbl[i].perr, tbl[i].serr, tbl[i].pd);
    end
    last_pd = 8'h96;

    // Stop error with the line left low: no new frame until the line has been high.
    hold(1'b1, 3);
    send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, fall);
    expect_frame("stop err", fall, 80, 1'b0, 1'b0, 1'b1, last_pd);
    hold(1'b0, 200);
    chk("break hold strobes", evq.size(), 0);
    evq.delete();
    hold(1'b1, 1);
    send_frame(8, 1'b0, 1'b0, 8'h66, 1'b0, 1'b1, 1'b0, fall);
    expect_frame("after break", fall, 80, 1'b1, 1'b0, 1'b0, 8'h66);

    // Short start glitch, then three back-to-back frames.
    bus.PRESCALE = 6'd16;
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 60);
    chk("glitch strobes", evq.size(), 0);
    evq.delete();
    send_frame(16, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, f0);
    send_frame(16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, fall);
    send_frame(16, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, fall);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("b2b strobe count", evq.size(), 3);
    if (evq.size() == 3) begin
      e0 = evq.pop_front();
      e1 = evq.pop_front();
      e2 = evq.pop_front();
      chk("b2b first latency", e0.cyc - f0, 162);
      chk("b2b gap 1", e1.cyc - e0.cyc, 160);
      chk("b2b gap 2", e2.cyc - e1.cyc, 160);
      chk("b2b data 0", e0.pd, 8'h01);
      chk("b2b data 1", e1.pd, 8'hFF);
      chk("b2b data 2", e2.pd, 8'h80);
      chk("b2b all valid", {e0.dv, e1.dv, e2.dv}, 3'b111);
    end
    evq.delete();

    // Reset in the middle of data bit 4 of 0xC3.
    hold(1'b1, 3);
    bus.PRESCALE = 6'd8;
    bus.PAR_EN = 1'b0;
    d = 8'hC3;
    hold(1'b0, 8);
    for (int i = 0; i < 4; i++) hold(d[i], 8);
    hold(d[4], 4);
    RST = 1'b0;
    #1;
    chk("mid reset P_DATA", bus.P_DATA, 0);
    chk("mid reset DATA_VALID", bus.DATA_VALID, 0);
    chk("mid reset PAR_ERR", bus.PAR_ERR, 0);
    chk("mid reset STP_ERR", bus.STP_ERR, 0);
    hold(1'b1, 3);
    RST = 1'b1;
    evq.delete();
    hold(1'b1, 5);
    send_frame(8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, fall);
    expect_frame("after reset", fall, 80, 1'b1, 1'b0, 1'b0, 8'h3C);

    // One-cycle low glitch at the centre of data bit 2 of 0xFF.
`ifdef UART_RX_MAJORITY_EN
    maj_exp = 8'hFF;
`else
    maj_exp = 8'hFB;
`endif
    hold(1'b1, 3);
    fall = cyc;
    hold(1'b0, 8);
    hold(1'b1, 16);
    hold(1'b1, 4);
    hold(1'b0, 1);
    hold(1'b1, 3);
    hold(1'b1, 48);
    expect_frame("centre glitch", fall, 80, 1'b1, 1'b0, 1'b0, maj_exp);
    last_pd = maj_exp;

    // Random frames; configuration is scrambled mid-frame to prove it is captured at start.
    for (int k = 0; k < 24; k++) begin
      p    = pick_prescale();
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      scr  = 1'($urandom_range(0, 1));
      gap  = $urandom_range(1, 4);
      exp_pe = pe && flip;
      exp_se = !stop;
      exp_dv = !exp_pe && !exp_se;
      if (exp_dv) last_pd = d;
      n = (2 + DW + int'(pe)) * p;
      hold(1'b1, gap);
      send_frame(p, pe, pt, d, flip, stop, scr, fall);
      expect_frame($sformatf("rand%0d", k), fall, n, exp_dv, exp_pe, exp_se, last_pd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receiver stage of the UART link. It oversamples the serial line RX_IN and deserialises LSB-first frames (start bit, DATA_WIDTH data bits, optional parity bit, stop bit). It checks parity and stop bit, then presents each good byte on P_DATA with a one-cycle DATA_VALID strobe. P_DATA/DATA_VALID connect directly to the system controller's RX_DATA_IN/RX_DATA_VALID inputs, so command bytes such as 0xAA enter the design through this block.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_WIDTH, 6, width of PRESCALE input
- CLK  in  1  oversampling clock, PRESCALE × baud rate
- RST  in  1  reset, asynchronous, active-low
- RX_IN  in  1  serial line, idles high, asynchronous to CLK
- PRESCALE  in  PRESCALE_WIDTH  CLK cycles per bit; legal values 8, 16, 32
- PAR_EN  in  1  1 = parity bit present in frame
- PAR_TYP  in  1  0 = even, 1 = odd parity
- P_DATA  out  DATA_WIDTH  last good received word
- DATA_VALID  out  1  one-cycle strobe, P_DATA holds a new good word
- PAR_ERR  out  1  one-cycle strobe, parity mismatch on the frame just ended
- STP_ERR  out  1  one-cycle strobe, stop bit sampled low

## Operation
- RX_IN passes through a 2-flop synchroniser; all behaviour below refers to the synchronised line (rx_s).
- Configuration capture: PRESCALE, PAR_EN and PAR_TYP are latched at start-bit detection and held for the whole frame. Changes mid-frame do not affect the frame in progress.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within each bit, wrapping to 0 at the end of the bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sample point: one sample at edge_cnt == PRESCALE/2 (see Configuration).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: edge_cnt = 0. When armed and rx_s == 0, go to START with edge_cnt <= 1, so the first low cycle is edge 0.
  - START: if the start sample is 1 (glitch), return to IDLE at the end of the bit with no strobe. Otherwise go to DATA at the end of the bit.
  - DATA: shift each sample into the shift register, LSB first. After bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN, else to STOP.
  - PARITY: compare the sample against XOR(data) ^ PAR_TYP. Record mismatch. Go to STOP at the end of the bit.
  - STOP: at the end of the stop bit, go to IDLE and issue exactly one of the outcomes below.
- Frame outcomes, issued in the cycle after the final stop edge:
  - Good frame: P_DATA <= shift register; DATA_VALID = 1.
  - Parity error: PAR_ERR = 1.
  - Stop error: STP_ERR = 1.
  - On any error, P_DATA keeps its previous value and DATA_VALID stays 0. PAR_ERR and STP_ERR may assert together.
- Re-arm rule: after an STP_ERR frame, IDLE requires rx_s == 1 for at least one cycle before detecting a new start bit (break protection). After a good frame, detection is immediate, which supports back-to-back frames.

## Timing
- Reset values: P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0, state IDLE, counters 0, armed = 1.
- Frame length: N = (2 + DATA_WIDTH + PAR_EN) × PRESCALE cycles, measured from the first rx_s low cycle to the final stop edge inclusive.
- Latency: outcome strobes assert N cycles after the first rx_s low cycle, i.e. N + 2 cycles after the RX_IN falling edge.
- All strobes are exactly one cycle wide. There is no back-pressure; the consumer must accept DATA_VALID in the cycle it asserts.
- Back-to-back frames: a start bit directly after a stop bit is detected in the strobe cycle, with no lost edge.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each bit takes three samples, at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the 2-of-3 majority.
  - All bit decisions (start, data, parity, stop) use the majority value.
- UART_RX_MAJORITY_EN undefined: a single sample at edge_cnt = PRESCALE/2.
- Frame timing and latency are identical in both builds.

## Test plan
- Basic receive: PRESCALE=8, PAR_EN=0, send 0xAA → DATA_VALID one cycle, P_DATA=0xAA, strobe 82 cycles after the RX_IN falling edge; PAR_ERR = STP_ERR = 0.
- Even parity: PRESCALE=16, PAR_EN=1, PAR_TYP=0:
  - Send 0x35 with parity 0 → P_DATA=0x35, DATA_VALID.
  - Repeat with parity 1 → PAR_ERR only; P_DATA stays 0x35.
- Stop error: PRESCALE=8, send 0x5A with the stop bit forced low and the line held low afterwards → STP_ERR once, no DATA_VALID, no new start detected until the line returns high.
- Start glitch and back-to-back frames:
  - RX_IN low for 2 cycles at PRESCALE=16 → no strobes, FSM back in IDLE.
  - Then 0x01, 0xFF, 0x80 back-to-back → three DATA_VALID strobes in order, exactly 160 cycles apart.
- Reset mid-frame: assert RST during data bit 4 of 0xC3 → all outputs 0 immediately. After release, 0x3C → P_DATA=0x3C.
- Majority vote (UART_RX_MAJORITY_EN build): PRESCALE=8, 1-cycle low glitch at edge 4 of a '1' data bit in 0xFF → P_DATA=0xFF. Without the macro, the same stimulus yields 0xFF with that bit cleared.
